// File: rtl/timer0_counter.sv
// 8-bit Timer/Counter0 in the style of the ATmega32A. It is clocked from clock50 and steps on
// synchronised cpu_clk edges. Define TIMER0_OC_TOGGLE_EN to build the OC0 toggle output.
module timer0_counter #(
    parameter int unsigned PRESCALE_WIDTH = 10
) (
    input  logic       clock50,
    input  logic       MR_n,
    input  logic       cpu_clk,
    input  logic [7:0] wdata,
    input  logic       tccr_wr,
    input  logic       tcnt_wr,
    input  logic       ocr_wr,
    input  logic       tov_clr,
    input  logic       ocf_clr,
    output logic [7:0] tcnt,
    output logic [7:0] ocr,
    output logic [3:0] tccr,
    output logic       tov,
    output logic       ocf
`ifdef TIMER0_OC_TOGGLE_EN
    ,
    output logic       oc0
`endif
);

    logic [2:0]                sync_q, sync_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [7:0]                tcnt_q, tcnt_d;
    logic [7:0]                ocr_q, ocr_d;
    logic [3:0]                tccr_q, tccr_d;
    logic                      tov_q, tov_d;
    logic                      ocf_q, ocf_d;
    logic                      cpu_tick;
    logic                      step_sel;
    logic                      step;
    logic                      match;
    logic                      tov_set;
    logic                      ocf_set;
    logic [2:0]                cs;
    logic                      ctc;

    assign cs  = tccr_q[2:0];
    assign ctc = tccr_q[3];

    // sync_q[1:0] is the synchroniser; sync_q[2] holds the previous value for edge detection
    assign sync_d   = {sync_q[1:0], cpu_clk};
    assign cpu_tick = sync_q[1] & ~sync_q[2];

    always_comb begin
        step_sel = 1'b0;
        unique case (cs)
            3'd1:    step_sel = 1'b1;
            3'd2:    step_sel = &prescale_q[2:0];
            3'd3:    step_sel = &prescale_q[5:0];
            3'd4:    step_sel = &prescale_q[7:0];
            3'd5:    step_sel = &prescale_q[9:0];
            default: step_sel = 1'b0;
        endcase
    end

    assign step  = cpu_tick & step_sel;
    assign match = (tcnt_q == ocr_q);

    always_comb begin
        prescale_d = prescale_q;
        if (tccr_wr || (cs == 3'd0)) begin
            prescale_d = '0;
        end else if (cpu_tick) begin
            prescale_d = prescale_q + {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        tcnt_d  = tcnt_q;
        tov_set = 1'b0;
        ocf_set = 1'b0;
        if (tcnt_wr) begin
            tcnt_d = wdata;
        end else if (step) begin
            // 0xFF always rolls to 0x00 in both modes, so overflow depends only on the old count
            tov_set = (tcnt_q == 8'hFF);
            ocf_set = match;
            tcnt_d  = (ctc && match) ? 8'h00 : tcnt_q + 8'd1;
        end
    end

    assign ocr_d  = ocr_wr ? wdata : ocr_q;
    assign tccr_d = tccr_wr ? wdata[3:0] : tccr_q;
    assign tov_d  = tov_set | (tov_q & ~tov_clr);
    assign ocf_d  = ocf_set | (ocf_q & ~ocf_clr);

    always_ff @(posedge clock50 or negedge MR_n) begin
        if (!MR_n) begin
            sync_q     <= '0;
            prescale_q <= '0;
            tcnt_q     <= '0;
            ocr_q      <= '0;
            tccr_q     <= '0;
            tov_q      <= 1'b0;
            ocf_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            prescale_q <= prescale_d;
            tcnt_q     <= tcnt_d;
            ocr_q      <= ocr_d;
            tccr_q     <= tccr_d;
            tov_q      <= tov_d;
            ocf_q      <= ocf_d;
        end
    end

`ifdef TIMER0_OC_TOGGLE_EN
    logic oc0_q, oc0_d;

    assign oc0_d = oc0_q ^ ocf_set;

    always_ff @(posedge clock50 or negedge MR_n) begin
        if (!MR_n) begin
            oc0_q <= 1'b0;
        end else begin
            oc0_q <= oc0_d;
        end
    end

    assign oc0 = oc0_q;
`endif

    assign tcnt = tcnt_q;
    assign ocr  = ocr_q;
    assign tccr = tccr_q;
    assign tov  = tov_q;
    assign ocf  = ocf_q;

endmodule

// File: tb/tb_timer0_counter.sv
// Bench for timer0_counter: directed scenarios with literal expectations plus randomized traffic,
// all compared every cycle against a behavioural model of the timer.
module tb_timer0_counter;

    logic       clock50 = 1'b0;
    logic       MR_n    = 1'b0;
    logic       cpu_clk = 1'b0;
    logic [7:0] wdata   = 8'h00;
    logic       tccr_wr = 1'b0;
    logic       tcnt_wr = 1'b0;
    logic       ocr_wr  = 1'b0;
    logic       tov_clr = 1'b0;
    logic       ocf_clr = 1'b0;
    logic [7:0] tcnt;
    logic [7:0] ocr;
    logic [3:0] tccr;
    logic       tov;
    logic       ocf;
`ifdef TIMER0_OC_TOGGLE_EN
    logic       oc0;
`endif

    int total = 0;
    int bad   = 0;

    timer0_counter dut (
        .clock50 (clock50),
        .MR_n    (MR_n),
        .cpu_clk (cpu_clk),
        .wdata   (wdata),
        .tccr_wr (tccr_wr),
        .tcnt_wr (tcnt_wr),
        .ocr_wr  (ocr_wr),
        .tov_clr (tov_clr),
        .ocf_clr (ocf_clr),
        .tcnt    (tcnt),
        .ocr     (ocr),
        .tccr    (tccr),
        .tov     (tov),
        .ocf     (ocf)
`ifdef TIMER0_OC_TOGGLE_EN
        ,
        .oc0     (oc0)
`endif
    );

    always #5 clock50 = ~clock50;

    // Behavioural model. Inputs change on the falling edge, so a cpu_clk rise seen at rising
    // edge k produces a tick that takes effect at rising edge k+2.
    int m_tcnt, m_ocr, m_cs, m_ctc, m_pre, m_tov, m_ocf, m_oc0;
    int seen1, seen2, seen3;

    function automatic int divisor(int cs);
        case (cs)
            1:       return 1;
            2:       return 8;
            3:       return 64;
            4:       return 256;
            5:       return 1024;
            default: return 0;
        endcase
    endfunction

    always @(posedge clock50 or negedge MR_n) begin
        if (!MR_n) begin
            m_tcnt = 0; m_ocr = 0; m_cs = 0; m_ctc = 0; m_pre = 0;
            m_tov = 0; m_ocf = 0; m_oc0 = 0;
            seen1 = 0; seen2 = 0; seen3 = 0;
        end else begin
            int  div;
            bit  tick, step, hit, set_tov, set_ocf;
            tick    = (seen2 == 1) && (seen3 == 0);
            div     = divisor(m_cs);
            step    = tick && (div != 0) && ((m_pre % div) == div - 1);
            hit     = (m_tcnt == m_ocr);
            set_tov = 0;
            set_ocf = 0;
            if (tcnt_wr) begin
                m_tcnt = int'(wdata);
            end else if (step) begin
                set_tov = (m_tcnt == 255);
                set_ocf = hit;
                m_tcnt  = (m_ctc == 1 && hit) ? 0 : (m_tcnt + 1) % 256;
            end
            if (tccr_wr || m_cs == 0) m_pre = 0;
            else if (tick)            m_pre = (m_pre + 1) % 1024;
            if (ocr_wr) m_ocr = int'(wdata);
            if (tccr_wr) begin
                m_cs  = int'(wdata[2:0]);
                m_ctc = int'(wdata[3]);
            end
            m_tov = set_tov ? 1 : (tov_clr ? 0 : m_tov);
            m_ocf = set_ocf ? 1 : (ocf_clr ? 0 : m_ocf);
            if (set_ocf) m_oc0 = 1 - m_oc0;
            seen3 = seen2;
            seen2 = seen1;
            seen1 = int'(cpu_clk);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock50) begin
        #1;
        chk("tcnt", int'(tcnt), m_tcnt);
        chk("ocr", int'(ocr), m_ocr);
        chk("tccr", int'(tccr), m_ctc * 8 + m_cs);
        chk("tov", int'(tov), m_tov);
        chk("ocf", int'(ocf), m_ocf);
`ifdef TIMER0_OC_TOGGLE_EN
        chk("oc0", int'(oc0), m_oc0);
`endif
    end

    task automatic wr(input int kind, input logic [7:0] d);
        wdata   = d;
        tccr_wr = (kind == 0);
        tcnt_wr = (kind == 1);
        ocr_wr  = (kind == 2);
        tov_clr = (kind == 3);
        ocf_clr = (kind == 4);
        @(negedge clock50);
        {tccr_wr, tcnt_wr, ocr_wr, tov_clr, ocf_clr} = '0;
    endtask

    task automatic tick();
        cpu_clk = 1'b1;
        repeat (3) @(negedge clock50);
        cpu_clk = 1'b0;
        repeat (3) @(negedge clock50);
    endtask

    // Raise cpu_clk and present a strobe exactly on the edge where the resulting step lands
    task automatic tick_with(input int kind, input logic [7:0] d);
        cpu_clk = 1'b1;
        repeat (2) @(negedge clock50);
        wr(kind, d);
        cpu_clk = 1'b0;
        repeat (3) @(negedge clock50);
    endtask

    task automatic rand_cycle();
        int r;
        r       = int'($urandom_range(0, 199));
        wdata   = 8'($urandom);
        tccr_wr = (r < 4);
        tcnt_wr = (r >= 4 && r < 10);
        ocr_wr  = (r >= 10 && r < 16);
        tov_clr = ($urandom_range(0, 9) == 0);
        ocf_clr = ($urandom_range(0, 9) == 0);
        if (tccr_wr) wdata[2:0] = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd1;
        if (tcnt_wr && $urandom_range(0, 1) == 1) wdata = 8'hFC;
        @(negedge clock50);
    endtask

`ifdef TIMER0_OC_TOGGLE_EN
    logic oc0_prev;
`endif

    initial begin
        repeat (3) @(negedge clock50);
        MR_n = 1'b1;
        @(negedge clock50);
        chk("reset_tcnt", int'(tcnt), 0);
        chk("reset_tccr", int'(tccr), 0);

        // Normal mode /1
        wr(0, 8'h01);
        wr(2, 8'h80);
        wr(1, 8'hFD);
        tick();
        chk("n1_tcnt_fe", int'(tcnt), 8'hFE);
        chk("n1_tov_0", int'(tov), 0);
        tick();
        chk("n1_tcnt_ff", int'(tcnt), 8'hFF);
        chk("n1_tov_0b", int'(tov), 0);
        tick();
        chk("n1_tcnt_00", int'(tcnt), 8'h00);
        chk("n1_tov_1", int'(tov), 1);
        chk("n1_ocf_0", int'(ocf), 0);

        // Prescale /8
        wr(0, 8'h02);
        wr(3, 8'h00);
        wr(1, 8'h00);
        repeat (7) tick();
        chk("p8_tcnt_7", int'(tcnt), 0);
        tick();
        chk("p8_tcnt_8", int'(tcnt), 1);
        repeat (8) tick();
        chk("p8_tcnt_16", int'(tcnt), 2);

        // CTC with ocr = 3
        wr(0, 8'h09);
        wr(2, 8'h03);
        wr(1, 8'h00);
        wr(4, 8'h00);
`ifdef TIMER0_OC_TOGGLE_EN
        oc0_prev = oc0;
`endif
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("ctc_tcnt", int'(tcnt), i % 4);
            if (i == 3) chk("ctc_ocf_pre", int'(ocf), 0);
            if (i == 4) chk("ctc_ocf_wrap", int'(ocf), 1);
`ifdef TIMER0_OC_TOGGLE_EN
            if (i == 4) chk("ctc_oc0", int'(oc0), int'(~oc0_prev));
            if (i == 8) chk("ctc_oc0_back", int'(oc0), int'(oc0_prev));
`endif
        end
        chk("ctc_tov", int'(tov), 0);

        // Collisions: tcnt write beats a matching step; a set beats ocf_clr
        wr(0, 8'h01);
        wr(2, 8'h05);
        wr(1, 8'h05);
        wr(4, 8'h00);
        tick_with(1, 8'h10);
        chk("col_tcnt", int'(tcnt), 8'h10);
        chk("col_ocf", int'(ocf), 0);
        wr(1, 8'h05);
        tick_with(4, 8'h00);
        chk("col_ocf_clr", int'(ocf), 1);
        chk("col_tcnt6", int'(tcnt), 6);

        // Stop, then /1024
        tick();
        tick();
        chk("stop_pre", int'(tcnt), 8);
        wr(0, 8'h00);
        repeat (3) tick();
        chk("stop_frozen", int'(tcnt), 8);
        wr(0, 8'h05);
        repeat (1023) tick();
        chk("p1024_none", int'(tcnt), 8);
        tick();
        chk("p1024_step", int'(tcnt), 9);

        // Asynchronous reset mid-count
        wr(0, 8'h01);
        wr(1, 8'h37);
        #2;
        MR_n = 1'b0;
        #1;
        chk("ar_tcnt", int'(tcnt), 0);
        chk("ar_ocr", int'(ocr), 0);
        chk("ar_tccr", int'(tccr), 0);
        chk("ar_flags", int'({tov, ocf}), 0);
        @(negedge clock50);
        MR_n = 1'b1;
        repeat (3) tick();
        chk("ar_no_count", int'(tcnt), 0);

        // Randomized traffic with legal cpu_clk phases
        wr(0, 8'h01);
        for (int t = 0; t < 400; t++) begin
            int hi, lo;
            hi = int'($urandom_range(3, 5));
            lo = int'($urandom_range(3, 5));
            cpu_clk = 1'b1;
            for (int c = 0; c < hi; c++) rand_cycle();
            cpu_clk = 1'b0;
            for (int c = 0; c < lo; c++) rand_cycle();
        end
        {tccr_wr, tcnt_wr, ocr_wr, tov_clr, ocf_clr} = '0;
        repeat (4) @(negedge clock50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer0_counter.md
# timer0_counter

8-bit timer/counter modelled on the ATmega32A Timer/Counter0; it sits directly downstream of the parametised clock divider and consumes its divided `clock` output as the emulated CPU clock. The divided clock is synchronised and edge-detected in the `clock50` domain, so the block runs entirely on `clock50`. A 10-bit prescaler selected by CS0[2:0] feeds the counter. The counter supports Normal and CTC modes, overflow/compare flags and an optional OC0 toggle output.

## Interface
- PRESCALE_WIDTH, 10, width of the free-running prescaler; must be ≥10 to support /1024.
- clock50  in  1  system clock; all state changes on its rising edge.
- MR_n  in  1  asynchronous, active-low master reset.
- cpu_clk  in  1  divided clock from the upstream divider; asynchronous to the logic, so it is synchronised internally.
- wdata  in  8  write data, shared by all register writes.
- tccr_wr  in  1  write strobe for TCCR0: wdata[2:0]=CS0, wdata[3]=CTC mode.
- tcnt_wr  in  1  write strobe for TCNT0.
- ocr_wr  in  1  write strobe for OCR0.
- tov_clr  in  1  clears TOV0.
- ocf_clr  in  1  clears OCF0.
- tcnt  out  8  current TCNT0.
- ocr  out  8  current OCR0.
- tccr  out  4  {CTC, CS0[2:0]}.
- tov  out  1  overflow flag.
- ocf  out  1  output-compare flag.
- oc0  out  1  compare-match toggle output; present only with the macro (see Configuration).

## Operation
- **cpu_tick generation:** a two-flop synchroniser on cpu_clk drives a rising-edge detector, giving a one-`clock50` pulse `cpu_tick`.
- **Prescaler:**
  - Increments on each cpu_tick while CS0≠0.
  - Held at 0 while CS0=0.
  - Cleared on any tccr_wr.
- **Timer step select** (on a cpu_tick, evaluated against the pre-increment prescaler value):
  - CS=1: every cpu_tick.
  - CS=2: when prescaler[2:0]=7.
  - CS=3: when prescaler[5:0]=63.
  - CS=4: when prescaler[7:0]=255.
  - CS=5: when prescaler[9:0]=1023.
  - CS=0, 6, 7: no steps. The external clock sources are unsupported and are treated as stopped.
- **Normal mode (CTC=0), on each step:**
  - tcnt ← tcnt+1, mod 256.
  - If tcnt was 0xFF, set tov.
  - If tcnt==ocr before the step, set ocf.
- **CTC mode (CTC=1), on each step:**
  - If tcnt==ocr: tcnt ← 0 and set ocf.
  - Otherwise: tcnt ← tcnt+1.
  - tov is set only on an actual 0xFF→0x00 transition. With ocr=0xFF, tov and ocf set on the same step.
- **Priorities and flags:**
  - tcnt_wr overrides a step in the same cycle: tcnt ← wdata, and no tov/ocf set that cycle.
  - ocr_wr takes effect immediately. A compare in the same cycle uses the old ocr.
  - Flags are sticky. A set condition beats a clear strobe in the same cycle.
- **Reset:** MR_n low asynchronously forces every register to 0 (tcnt, ocr, tccr, prescaler, synchroniser, tov, ocf, oc0) at any point, including mid-count. Counting resumes only after CS0 is written nonzero.

## Timing
- cpu_clk rising edge → cpu_tick: 2–3 `clock50` cycles (synchroniser uncertainty).
- cpu_tick → tcnt/tov/ocf update: registered on the same `clock50` edge that samples cpu_tick, so visible 1 cycle after cpu_tick is high.
- Register writes: visible on outputs the cycle after the strobe.
- Assumption on cpu_clk: high and low phases each ≥3 `clock50` cycles. Faster inputs drop ticks; this is not checked.

## Configuration
- **TIMER0_OC_TOGGLE_EN**
  - Defined: oc0 port exists and toggles on every step that sets ocf (writes to tcnt do not toggle it). Reset value is 0.
  - Undefined: oc0 port and its flop are removed, and flags behave identically.

## Test plan
- **Reset:** MR_n pulsed low mid-count at tcnt=0x37 → all outputs 0 immediately, without waiting for a clock edge; no steps after release until tccr_wr.
- **Normal mode, /1:** CS=1, tcnt_wr 0xFD, 3 cpu_ticks → tcnt FE, FF, 00; tov set on the third step only; ocf stays 0 with ocr=0x80.
- **Prescale /8:** CS=2, 16 cpu_ticks from tcnt=0 → tcnt=2; steps occur on ticks 8 and 16.
- **CTC mode:** CTC=1, CS=1, ocr=0x03 → tcnt sequence 0,1,2,3,0,1…; ocf set on each 3→0 step; tov never set; oc0 toggles on each wrap (macro defined).
- **Collisions:**
  - tcnt_wr 0x10 coincident with a step from tcnt=ocr → tcnt=0x10, ocf unchanged.
  - ocf_clr coincident with a match → ocf remains 1.
- **Stop:** write CS=0 mid-count → tcnt frozen, prescaler cleared; re-enable CS=5 → first step after 1024 cpu_ticks.
